// File: rtl/instr_encoder.sv
// instr_encoder: two-stage pipelined RISC-V instruction encoder.
// Packs decoded fields (format, registers, funct bits, 32-bit signed immediate)
// into a 32-bit instruction word tagged with an auto-incrementing byte address.
// Immediates that do not fit the target format, bad shift encodings and
// fmt=7 raise out_err and emit a NOP (addi x0,x0,0) instead.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   clear                 synchronous flush; address counter back to BASE_ADDR
//   in_valid / in_ready   input handshake for fmt, funct3, funct7, rd, rs1, rs2, imm
//   out_valid / out_ready output handshake for out_instr, out_addr, out_err
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  fmt,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        out_err
);

    localparam int STAGES = 2;

    localparam logic [2:0] F_IARITH = 3'd0;
    localparam logic [2:0] F_ISHIFT = 3'd1;
    localparam logic [2:0] F_LOAD   = 3'd2;
    localparam logic [2:0] F_STORE  = 3'd3;
    localparam logic [2:0] F_BRANCH = 3'd4;
    localparam logic [2:0] F_LUI    = 3'd5;
    localparam logic [2:0] F_JAL    = 3'd6;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } req_t;

    // vld_pipe[1] = stage A (raw fields), vld_pipe[2] = stage B (encoded word)
    logic [STAGES:1] vld_pipe;
    req_t            a_q;
    req_t            req;
    logic [31:0]     addr_q;
    logic [31:0]     enc;
    logic            bad;
    logic            b_load;
    logic            a_load;
    logic            out_fire;
    logic signed [31:0] simm;

    assign req       = '{fmt: fmt, funct3: funct3, funct7: funct7, rd: rd,
                         rs1: rs1, rs2: rs2, imm: imm};
    assign out_valid = vld_pipe[2];
    assign out_addr  = addr_q;
    assign out_fire  = vld_pipe[2] && out_ready;
    assign b_load    = !vld_pipe[2] || out_ready;
    assign a_load    = !vld_pipe[1] || b_load;
    assign in_ready  = a_load;
    assign simm      = $signed(a_q.imm);

    // Encoding and range checks sit between stage A and stage B.
    always_comb begin
        enc = NOP;
        bad = 1'b0;
        case (a_q.fmt)
            F_IARITH, F_LOAD: begin
                enc = {a_q.imm[11:0], a_q.rs1, a_q.funct3, a_q.rd,
                       (a_q.fmt == F_LOAD) ? OP_LOAD : OP_IMM};
                bad = (simm < -32'sd2048) || (simm > 32'sd2047);
            end
            F_ISHIFT: begin
                enc = {a_q.funct7, a_q.imm[4:0], a_q.rs1, a_q.funct3, a_q.rd, OP_IMM};
                bad = (a_q.imm[31:5] != 27'd0)
                   || !((a_q.funct3 == 3'b001) || (a_q.funct3 == 3'b101))
                   || !((a_q.funct7 == 7'b0000000) || (a_q.funct7 == 7'b0100000));
            end
            F_STORE: begin
                enc = {a_q.imm[11:5], a_q.rs2, a_q.rs1, a_q.funct3, a_q.imm[4:0], OP_STORE};
                bad = (simm < -32'sd2048) || (simm > 32'sd2047);
            end
            F_BRANCH: begin
                enc = {a_q.imm[12], a_q.imm[10:5], a_q.rs2, a_q.rs1, a_q.funct3,
                       a_q.imm[4:1], a_q.imm[11], OP_BRANCH};
                // with imm[0]=0 the upper bound 4095 collapses to 4094
                bad = (simm < -32'sd4096) || (simm > 32'sd4095) || a_q.imm[0];
            end
            F_LUI: begin
                enc = {a_q.imm[31:12], a_q.rd, OP_LUI};
                bad = (a_q.imm[11:0] != 12'd0);
            end
            F_JAL: begin
                enc = {a_q.imm[20], a_q.imm[10:1], a_q.imm[11], a_q.imm[19:12],
                       a_q.rd, OP_JAL};
                bad = (simm < -32'sd1048576) || (simm > 32'sd1048575) || a_q.imm[0];
            end
            default: bad = 1'b1;
        endcase
        if (bad) enc = NOP;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe  <= '0;
            a_q       <= '0;
            out_instr <= 32'd0;
            out_err   <= 1'b0;
            addr_q    <= BASE_ADDR;
        end else if (clear) begin
            // flush wins over any handshake; the presented word is dropped
            vld_pipe <= '0;
            addr_q   <= BASE_ADDR;
        end else begin
            if (out_fire) addr_q <= addr_q + 32'd4;
            if (b_load) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) begin
                    out_instr <= enc;
                    out_err   <= bad;
                end
            end
            if (a_load) begin
                vld_pipe[1] <= in_valid;
                if (in_valid) a_q <= req;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed test-plan words with known
// encodings, backpressure, clear and async reset, then randomized traffic
// checked against an arithmetic reference model and an in-order scoreboard.
module tb_instr_encoder;

    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset, clear, in_valid, in_ready, out_valid, out_ready, out_err;
    logic [2:0]  fmt, funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm, out_instr, out_addr;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [32:0] kexp;   // {err, instr} when known
        logic        known;
    } vec_t;

    instr_encoder #(.BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .funct3(funct3), .funct7(funct7),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_fire = 0;
    logic [32:0] exp_q[$];
    logic [31:0] exp_addr = BASE;
    bit          hold_chk = 0;
    logic [31:0] h_instr, h_addr;
    logic        h_err;
    bit          last_acc, last_rdy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: instruction built as a sum of shifted field values.
    function automatic logic [32:0] model(input vec_t v);
        longint u  = longint'(v.imm);
        longint s  = longint'($signed(v.imm));
        longint r1 = longint'(v.rs1), r2 = longint'(v.rs2), d = longint'(v.rd);
        longint f3 = longint'(v.f3), f7 = longint'(v.f7);
        longint w  = 0;
        bit     err = 0;
        case (v.fmt)
            3'd0, 3'd2: begin
                err = (s < -2048) || (s > 2047);
                w = ((u % 4096) << 20) + (r1 << 15) + (f3 << 12) + (d << 7)
                  + ((v.fmt == 3'd0) ? 19 : 3);
            end
            3'd1: begin
                err = (u >= 32) || !(f3 == 1 || f3 == 5) || !(f7 == 0 || f7 == 32);
                w = (f7 << 25) + ((u % 32) << 20) + (r1 << 15) + (f3 << 12) + (d << 7) + 19;
            end
            3'd3: begin
                err = (s < -2048) || (s > 2047);
                w = (((u >> 5) % 128) << 25) + (r2 << 20) + (r1 << 15) + (f3 << 12)
                  + ((u % 32) << 7) + 35;
            end
            3'd4: begin
                err = (s < -4096) || (s > 4094) || (u % 2 == 1);
                w = (((u >> 12) % 2) << 31) + (((u >> 5) % 64) << 25) + (r2 << 20)
                  + (r1 << 15) + (f3 << 12) + (((u >> 1) % 16) << 8)
                  + (((u >> 11) % 2) << 7) + 99;
            end
            3'd5: begin
                err = (u % 4096) != 0;
                w = ((u / 4096) << 12) + (d << 7) + 55;
            end
            3'd6: begin
                err = (s < -(longint'(1) << 20)) || (s > (longint'(1) << 20) - 2) || (u % 2 == 1);
                w = (((u >> 20) % 2) << 31) + (((u >> 1) % 1024) << 21)
                  + (((u >> 11) % 2) << 20) + (((u >> 12) % 256) << 12) + (d << 7) + 111;
            end
            default: err = 1;
        endcase
        if (err) w = 19;
        return {err, w[31:0]};
    endfunction

    function automatic vec_t mk(input logic [2:0] f, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [4:0] d, input logic [4:0] a, input logic [4:0] b,
                                input logic [31:0] i, input logic [32:0] k);
        vec_t v;
        v = '{fmt: f, f3: f3, f7: f7, rd: d, rs1: a, rs2: b, imm: i, kexp: k, known: 1'b1};
        return v;
    endfunction

    function automatic vec_t rnd_vec();
        vec_t v;
        int   bnd[14] = '{-2049, -2048, 2047, 2048, -4097, -4096, 4094, 4095, 4096,
                          -1048576, -1048578, 1048574, 1048576, 32};
        logic [31:0] t;
        v = '0;
        v.fmt = 3'($urandom_range(0, 7));
        v.f3  = 3'($urandom_range(0, 7));
        v.f7  = 7'($urandom_range(0, 127));
        v.rd  = 5'($urandom_range(0, 31));
        v.rs1 = 5'($urandom_range(0, 31));
        v.rs2 = 5'($urandom_range(0, 31));
        if (v.fmt == 3'd1 && $urandom_range(0, 3) != 0) begin
            v.f3 = $urandom_range(0, 1) ? 3'd5 : 3'd1;
            v.f7 = $urandom_range(0, 1) ? 7'd32 : 7'd0;
        end
        case ($urandom_range(0, 3))
            0: v.imm = 32'($urandom_range(0, 4095)) - 32'd2048;
            1: v.imm = 32'(bnd[$urandom_range(0, 13)]);
            2: v.imm = $urandom;
            default: v.imm = 32'($urandom_range(0, 40));
        endcase
        if ((v.fmt == 3'd4 || v.fmt == 3'd6) && $urandom_range(0, 3) != 0) v.imm[0] = 1'b0;
        if (v.fmt == 3'd5 && $urandom_range(0, 3) != 0) begin
            t = $urandom;
            v.imm = t & 32'hFFFF_F000;
        end
        return v;
    endfunction

    // One clock cycle: drive, sample just after settling, score handshakes.
    task automatic cyc(input bit iv, input vec_t v, input bit ordy, input bit clr);
        logic [32:0] e;
        in_valid = iv; fmt = v.fmt; funct3 = v.f3; funct7 = v.f7;
        rd = v.rd; rs1 = v.rs1; rs2 = v.rs2; imm = v.imm;
        out_ready = ordy; clear = clr;
        #1;
        if (hold_chk) begin
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_instr", out_instr, h_instr);
            chk("hold_addr", out_addr, h_addr);
            chk("hold_err", {31'd0, out_err}, {31'd0, h_err});
        end
        hold_chk = out_valid && !out_ready && !clr;
        h_instr = out_instr; h_addr = out_addr; h_err = out_err;
        last_rdy = in_ready;
        last_acc = in_valid && in_ready && !clr;
        if (clr) begin
            exp_q.delete();
            exp_addr = BASE;
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_word", {31'd0, out_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("instr", out_instr, e[31:0]);
                    chk("err", {31'd0, out_err}, {31'd0, e[32]});
                    chk("addr", out_addr, exp_addr);
                    exp_addr = exp_addr + 32'd4;
                    n_fire++;
                end
            end
            if (last_acc) exp_q.push_back(v.known ? v.kexp : model(v));
        end
        @(posedge clk); #1;
    endtask

    vec_t dir[12];
    vec_t idle;
    int   f0, idx;

    initial begin
        idle = '0;
        dir[0]  = mk(3'd0, 3'd0, 7'd0,  5'd1, 5'd0, 5'd0, 32'd5,          {1'b0, 32'h00500093});
        dir[1]  = mk(3'd3, 3'd2, 7'd0,  5'd0, 5'd2, 5'd5, 32'd8,          {1'b0, 32'h00512423});
        dir[2]  = mk(3'd4, 3'd0, 7'd0,  5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC,  {1'b0, 32'hFE208EE3});
        dir[3]  = mk(3'd6, 3'd0, 7'd0,  5'd1, 5'd0, 5'd0, 32'd2048,       {1'b0, 32'h001000EF});
        dir[4]  = mk(3'd5, 3'd0, 7'd0,  5'd5, 5'd0, 5'd0, 32'h1234_5000,  {1'b0, 32'h123452B7});
        dir[5]  = mk(3'd1, 3'd5, 7'h20, 5'd3, 5'd4, 5'd0, 32'd7,          {1'b0, 32'h40725193});
        dir[6]  = mk(3'd1, 3'd5, 7'h20, 5'd3, 5'd4, 5'd0, 32'd32,         {1'b1, 32'h00000013});
        dir[7]  = mk(3'd0, 3'd0, 7'd0,  5'd1, 5'd0, 5'd0, 32'd2048,       {1'b1, 32'h00000013});
        dir[8]  = mk(3'd4, 3'd0, 7'd0,  5'd0, 5'd1, 5'd2, 32'd3,          {1'b1, 32'h00000013});
        dir[9]  = mk(3'd5, 3'd0, 7'd0,  5'd5, 5'd0, 5'd0, 32'd1,          {1'b1, 32'h00000013});
        dir[10] = mk(3'd7, 3'd0, 7'd0,  5'd1, 5'd1, 5'd1, 32'd0,          {1'b1, 32'h00000013});
        dir[11] = mk(3'd0, 3'd0, 7'd0,  5'd0, 5'd0, 5'd0, 32'hFFFF_F800,  {1'b0, 32'h80000013});

        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        fmt = '0; funct3 = '0; funct7 = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_addr", out_addr, BASE);
        chk("rst_out_err", {31'd0, out_err}, 32'd0);
        reset = 1'b0;

        // latency: accepted in N, visible in N+2
        cyc(1, dir[0], 1, 0);
        chk("lat_n1_valid", {31'd0, out_valid}, 32'd0);
        cyc(0, idle, 1, 0);
        chk("lat_n2_valid", {31'd0, out_valid}, 32'd1);
        chk("lat_n2_instr", out_instr, 32'h00500093);
        f0 = n_fire;
        for (int i = 1; i < 12; i++) cyc(1, dir[i], 1, 0);
        cyc(0, idle, 1, 0);
        cyc(0, idle, 1, 0);
        chk("throughput", 32'(n_fire - f0), 32'd12);

        // backpressure: three words, sink stalled for five cycles
        cyc(0, idle, 1, 1);
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            cyc(idx < 3, (idx < 3) ? dir[idx] : idle, 0, 0);
            if (c >= 2) chk("bp_in_ready", {31'd0, last_rdy}, 32'd0);
            if (last_acc) idx++;
        end
        chk("bp_accepts", 32'(idx), 32'd2);
        for (int c = 0; c < 10 && (idx < 3 || exp_q.size() != 0); c++) begin
            cyc(idx < 3, (idx < 3) ? dir[idx] : idle, 1, 0);
            if (last_acc) idx++;
        end
        chk("bp_drained", 32'(exp_q.size()), 32'd0);
        chk("bp_next_addr", out_addr, BASE + 32'd12);

        // clear with both stages full
        cyc(1, dir[1], 0, 0);
        cyc(1, dir[2], 0, 0);
        cyc(0, idle, 1, 1);
        chk("clr_valid", {31'd0, out_valid}, 32'd0);
        chk("clr_addr", out_addr, BASE);
        cyc(1, dir[3], 1, 0);
        cyc(0, idle, 1, 0);
        chk("clr_first_addr", out_addr, BASE);
        cyc(0, idle, 1, 0);

        // asynchronous reset mid-stream
        cyc(1, dir[4], 0, 0);
        cyc(1, dir[5], 0, 0);
        #1 reset = 1'b1;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("arst_instr", out_instr, 32'd0);
        chk("arst_addr", out_addr, BASE);
        exp_q.delete(); exp_addr = BASE; hold_chk = 0;
        @(posedge clk); #1 reset = 1'b0;
        for (int c = 0; c < 4; c++) cyc(0, idle, 1, 0);
        chk("arst_no_stale", {31'd0, out_valid}, 32'd0);

        // randomized traffic with random backpressure
        for (int c = 0; c < 400; c++)
            cyc($urandom_range(0, 3) != 0, rnd_vec(), $urandom_range(0, 9) < 7, 0);
        for (int c = 0; c < 20 && (exp_q.size() != 0 || out_valid); c++) cyc(0, idle, 1, 0);
        chk("final_drain", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
